// File: rtl/bpf_fetch.sv
// bpf_fetch: fetch/PC unit; reads one instruction on STEP1 and commits the next PC on STEP5.
module bpf_fetch #(
  parameter int PC_WIDTH    = 8,
  parameter int PROG_LEN    = 256,
  parameter int ACK_TIMEOUT = 3
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iSTEP1,
  input  logic                iSTEP5,
  input  logic                iBR_TAKE,
  input  logic                iIMEM_ACK,
  input  logic [63:0]         iIMEM_DATA,
  output logic                oIMEM_REQ,
  output logic [PC_WIDTH-1:0] oIMEM_ADDR,
  output logic [PC_WIDTH-1:0] oPC,
  output logic [15:0]         oOPCODE,
  output logic [7:0]          oJT,
  output logic [7:0]          oJF,
  output logic [31:0]         oK,
  output logic                oINSN_VALID,
  output logic                oHALT,
  output logic                oFAULT
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WAIT, VALID, HALT, FAULT} state_t;
  state_t state, stateNext;
  logic [CW-1:0] cnt, cntNext, cntInc;
  logic [PC_WIDTH-1:0] pcNext, addrNext;
  logic reqNext, validNext, haltNext, faultNext, latch;
  logic isJmp, isRet;
  logic [31:0] jmpOff;
  logic [32:0] nextPc;
  assign cntInc = cnt + 1'b1;
  assign isJmp  = oOPCODE[2:0] == 3'd5;
  assign isRet  = oOPCODE[2:0] == 3'd6;
  assign jmpOff = oOPCODE[7:4] == 4'd0 ? oK : {24'd0, iBR_TAKE ? oJT : oJF};
  // Widened so a large k or an offset past the end can never wrap back into range.
  assign nextPc = {{(33-PC_WIDTH){1'b0}}, oPC} + 33'd1 + (isJmp ? {1'b0, jmpOff} : 33'd0);
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    pcNext    = oPC;
    addrNext  = oIMEM_ADDR;
    reqNext   = oIMEM_REQ;
    validNext = oINSN_VALID;
    haltNext  = oHALT;
    faultNext = oFAULT;
    latch     = 1'b0;
    case (state)
      IDLE: if (iSTEP1) begin
        stateNext = WAIT;
        reqNext   = 1'b1;
        addrNext  = oPC;
        cntNext   = '0;
      end
      WAIT: if (iSTEP1 || (!iIMEM_ACK && cntInc == CW'(ACK_TIMEOUT))) begin
        stateNext = FAULT;
        reqNext   = 1'b0;
        faultNext = 1'b1;
      end else if (iIMEM_ACK) begin
        stateNext = VALID;
        reqNext   = 1'b0;
        validNext = 1'b1;
        latch     = 1'b1;
      end else begin
        cntNext = cntInc;
      end
      VALID: if (iSTEP1) begin
        stateNext = FAULT;
        faultNext = 1'b1;
      end else if (iSTEP5) begin
        if (isRet) begin
          stateNext = HALT;
          haltNext  = 1'b1;
          validNext = 1'b0;
        end else if (nextPc >= 33'(PROG_LEN)) begin
          stateNext = FAULT;
          faultNext = 1'b1;
        end else begin
          stateNext = IDLE;
          pcNext    = nextPc[PC_WIDTH-1:0];
          validNext = 1'b0;
        end
      end
      default: reqNext = 1'b0;
    endcase
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= IDLE;
      cnt         <= '0;
      oPC         <= '0;
      oIMEM_ADDR  <= '0;
      oIMEM_REQ   <= 1'b0;
      oINSN_VALID <= 1'b0;
      oHALT       <= 1'b0;
      oFAULT      <= 1'b0;
      oOPCODE     <= '0;
      oJT         <= '0;
      oJF         <= '0;
      oK          <= '0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      oPC         <= pcNext;
      oIMEM_ADDR  <= addrNext;
      oIMEM_REQ   <= reqNext;
      oINSN_VALID <= validNext;
      oHALT       <= haltNext;
      oFAULT      <= faultNext;
      if (latch) {oOPCODE, oJT, oJF, oK} <= iIMEM_DATA;
    end
  end
endmodule

// File: doc/bpf_fetch.md
Name: bpf_fetch

Overview:
Instruction fetch and PC unit of the multi-cycle BPF core. It sits directly downstream of the five-phase step generator and consumes its one-hot step strobes. On STEP1 it reads one 64-bit classic-BPF instruction from instruction memory and presents the decoded fields to the decode/execute stages. On STEP5 it commits the next PC, taking jumps and returns into account.

Parameters:
PC_WIDTH, 8, width of program counter / instruction memory address
PROG_LEN, 256, number of valid instruction slots; a PC at or above this value is a fault
ACK_TIMEOUT, 3, max cycles oIMEM_REQ may stay high without iIMEM_ACK before a fault

Ports:
iCLK  in  1  clock
iRST  in  1  reset, synchronous, active-high
iSTEP1  in  1  fetch phase strobe, one cycle wide
iSTEP5  in  1  commit phase strobe, one cycle wide
iBR_TAKE  in  1  conditional-jump result from ALU, valid while iSTEP5 is high
iIMEM_ACK  in  1  instruction memory data valid
iIMEM_DATA  in  64  instruction word {code[63:48], jt[47:40], jf[39:32], k[31:0]}
oIMEM_REQ  out  1  read request, held until ack or timeout
oIMEM_ADDR  out  PC_WIDTH  read address, equals PC while oIMEM_REQ is high
oPC  out  PC_WIDTH  current program counter
oOPCODE  out  16  latched code field
oJT  out  8  latched jump-true offset
oJF  out  8  latched jump-false offset
oK  out  32  latched immediate
oINSN_VALID  out  1  latched instruction fields are valid
oHALT  out  1  RET executed; sticky
oFAULT  out  1  fetch or PC fault; sticky

Behaviour:
- Reset (synchronous, iRST high at a rising iCLK edge):
  - PC = 0; all outputs = 0; timeout counter = 0; state IDLE.
  - Any outstanding request is abandoned, and an ack arriving after reset is ignored.
- States: IDLE, WAIT, VALID, HALT, FAULT. All outputs are registered.
- IDLE:
  - iSTEP1 sampled high -> next cycle oIMEM_REQ=1, oIMEM_ADDR=PC, counter cleared, go to WAIT.
  - iSTEP5 in IDLE is ignored.
- WAIT:
  - iIMEM_ACK high -> latch fields from iIMEM_DATA, oIMEM_REQ=0, oINSN_VALID=1 on the next cycle, go to VALID.
  - No ack -> counter increments. When the counter reaches ACK_TIMEOUT without an ack -> oIMEM_REQ=0, oFAULT=1, go to FAULT.
  - Ack in the same cycle the counter would expire -> the ack wins.
  - iSTEP1 in WAIT (overrun) -> FAULT.
- VALID: fields stay stable until iSTEP5. On iSTEP5, with class = code[2:0] and op = code[7:4], PC is computed as:
  - class 5 (JMP), op 0 (JA): next = PC + 1 + k.
  - class 5, other op: next = PC + 1 + (iBR_TAKE ? jt : jf); jt and jf are zero-extended.
  - class 6 (RET): PC unchanged, oHALT=1, oINSN_VALID=0, go to HALT.
  - All other classes: next = PC + 1.
- Next-PC arithmetic:
  - Computed in 33 bits.
  - If next >= PROG_LEN: PC unchanged, oFAULT=1, go to FAULT.
  - Otherwise PC = next[PC_WIDTH-1:0], oINSN_VALID=0, go to IDLE.
- iSTEP1 in VALID (no commit yet) -> FAULT.
- HALT and FAULT are sticky until reset: all strobes are ignored and oIMEM_REQ stays 0. Latched fields hold their last values.
- Latency:
  - Request is asserted 1 cycle after iSTEP1.
  - oINSN_VALID is asserted 1 cycle after the ack.
  - PC is updated 1 cycle after iSTEP5.

Test Plan:
- Reset, memory acks in the first request cycle with a LD word (code 0x0020), then STEP1..STEP5 -> oIMEM_ADDR=0, oINSN_VALID one cycle after ack, oK latched, PC=1 after STEP5.
- JEQ at PC=4 (code 0x0015, jt=2, jf=0): iBR_TAKE=1 -> PC=7; iBR_TAKE=0 -> PC=5.
- JA at PC=10 with k=0x20 -> PC=43. JA at PC=250 with k=10 (PROG_LEN 256) -> oFAULT=1, PC stays 250.
- RET (code 0x0006) at PC=3 -> oHALT=1 after STEP5. Subsequent STEP1 produces no oIMEM_REQ, and PC stays 3.
- Ack withheld -> oIMEM_REQ held exactly ACK_TIMEOUT cycles, then oFAULT=1. Ack arriving in the expiry cycle -> no fault, oINSN_VALID=1.
- iRST during WAIT, ack one cycle later -> outputs all 0, PC=0, ack ignored, normal fetch on the next STEP1.
